// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
// Holds funct3 codes, FSM states, latched load context and access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] off;
  } ld_ctx_t;

  // Access size in bytes; low two funct3 bits select B/H/W.
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    logic [2:0] s;
    s = 3'd1;
    case (f3[1:0])
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_mem_master_load_align.sv
// Load data aligner: selects byte/half/word lane and sign/zero extends.
// Ports: funct3, offset (byte lane), word (raw memory word) -> result.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (offset)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = 32'h0;
    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_BU:   result = {24'h0, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_HU:   result = {16'h0, lane_h};
      F3_W:    result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store master: byte-masked word accesses to a synchronous memory,
// one response per request. Ports: req_*, resp_*, mem_*. Macro: LSU_MISALIGN_TRAP_EN.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata
);

  state_t      state_q, state_d;
  ld_ctx_t     ctx_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        is_b, is_h, is_w;
  logic [1:0]  off;
  logic        misal, illegal, range_err, fault;
  logic        accept, go;
  logic [32:0] end_addr;
  logic [3:0]  mask;
  logic [31:0] ld_data;

  assign is_b = req_funct3[1:0] == 2'b00;
  assign is_h = req_funct3[1:0] == 2'b01;
  assign is_w = req_funct3[1:0] == 2'b10;

`ifdef LSU_MISALIGN_TRAP_EN
  assign off   = req_addr[1:0];
  assign misal = (is_h && req_addr[0]) || (is_w && |req_addr[1:0]);
`else
  // Misaligned accesses silently round down to their natural boundary.
  assign off   = is_w ? 2'b00 : (is_h ? {req_addr[1], 1'b0} : req_addr[1:0]);
  assign misal = 1'b0;
`endif

  always_comb begin
    illegal = 1'b0;
    if (req_is_store)
      illegal = req_funct3[2] || (req_funct3 == 3'b011);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                (req_funct3 == 3'b111);
  end

  // Range uses the raw address so a wrapped tail still faults.
  assign end_addr  = {1'b0, req_addr} + 33'(size_of(req_funct3)) - 33'd1;
  assign range_err = end_addr >= 33'(MEM_BYTES);
  assign fault     = illegal || misal || range_err;

  assign req_ready = state_q == IDLE;
  assign accept    = req_valid && req_ready;
  assign go        = accept && !fault && !rst;

  always_comb begin
    mask = 4'b1111;
    unique case (1'b1)
      is_b:    mask = 4'b0001 << off;
      is_h:    mask = 4'b0011 << off;
      default: mask = 4'b1111;
    endcase
  end

  always_comb begin
    mem_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00:   mem_wdata = {4{req_wdata[7:0]}};
      2'b01:   mem_wdata = {2{req_wdata[15:0]}};
      default: mem_wdata = req_wdata;
    endcase
  end

  assign mem_addr = {req_addr[31:2], off};
  assign mem_ren  = go && !req_is_store;
  assign mem_wen  = go && req_is_store;
  assign mem_mask = mem_wen ? mask : 4'b0000;

  lsu_load_align u_align (
    .funct3 (ctx_q.f3),
    .offset (ctx_q.off),
    .word   (mem_rdata),
    .result (ld_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept)
          state_d = (fault || req_is_store) ? RESP : RD_WAIT;
      RD_WAIT:
        state_d = RESP;
      RESP:
        if (resp_ready)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctx_q   <= '0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctx_q   <= '{f3: req_funct3, off: off};
        rdata_q <= 32'h0;
        fault_q <= fault;
      end else if (state_q == RD_WAIT) begin
        rdata_q <= ld_data;
      end
    end
  end

  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-masked synchronous memory model.
// Table of load/store vectors plus stall and reset-in-flight sequences.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_BYTES(131072)) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_is_store (req_is_store), .req_funct3 (req_funct3),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_rdata (resp_rdata), .resp_fault (resp_fault),
    .mem_addr (mem_addr), .mem_ren (mem_ren), .mem_wen (mem_wen),
    .mem_wdata (mem_wdata), .mem_mask (mem_mask), .mem_rdata (mem_rdata)
  );

  logic [31:0] mem [32768];

  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b])
          mem[mem_addr[16:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_ren)
      mem_rdata <= mem[mem_addr[16:2]];
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] wdx;
    logic [31:0] rd;
    logic        flt;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wd, logic [31:0] maddr,
                              logic [3:0] mask, logic [31:0] wdx,
                              logic [31:0] rd, logic flt, int lat);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.maddr = maddr;
    v.mask = mask; v.wdx = wdx; v.rd = rd; v.flt = flt; v.lat = lat;
    return v;
  endfunction

  task automatic drive(input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_is_store = st;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 6) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    drive(v.st, v.f3, v.addr, v.wd);
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " mem_ren"}, 32'(mem_ren), 32'(!v.st && !v.flt));
    check({tag, " mem_wen"}, 32'(mem_wen), 32'(v.st && !v.flt));
    check({tag, " mem_mask"}, 32'(mem_mask), 32'(v.mask));
    check({tag, " mem_addr"}, mem_addr, v.maddr);
    if (v.st && !v.flt)
      check({tag, " mem_wdata"}, mem_wdata, v.wdx);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(cyc);
    check({tag, " latency"}, 32'(cyc), 32'(v.lat));
    check({tag, " rdata"}, resp_rdata, v.rd);
    check({tag, " fault"}, 32'(resp_fault), 32'(v.flt));
    handshake();
    check({tag, " valid_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    resp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h100, 32'h0);

    vecs.push_back(mk(1, 3'b010, 32'h100, 32'h8844_22F1, 32'h100, 4'hF,
                      32'h8844_22F1, 0, 0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h200, 32'h1122_3344, 32'h200, 4'hF,
                      32'h1122_3344, 0, 0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h204, 32'h0, 32'h204, 4'hF, 32'h0,
                      0, 0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h1FFFC, 32'h7F00_0000, 32'h1FFFC, 4'hF,
                      32'h7F00_0000, 0, 0, 1));
    vecs.push_back(mk(0, 3'b000, 32'h100, 0, 32'h100, 0, 0,
                      32'hFFFF_FFF1, 0, 2));
    vecs.push_back(mk(0, 3'b100, 32'h103, 0, 32'h103, 0, 0,
                      32'h0000_0088, 0, 2));
    vecs.push_back(mk(0, 3'b001, 32'h102, 0, 32'h102, 0, 0,
                      32'hFFFF_8844, 0, 2));
    vecs.push_back(mk(0, 3'b101, 32'h100, 0, 32'h100, 0, 0,
                      32'h0000_22F1, 0, 2));
    vecs.push_back(mk(0, 3'b010, 32'h100, 0, 32'h100, 0, 0,
                      32'h8844_22F1, 0, 2));
    vecs.push_back(mk(1, 3'b000, 32'h202, 32'h1234_56AB, 32'h202, 4'b0100,
                      32'hABAB_ABAB, 0, 0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h200, 0, 32'h200, 0, 0,
                      32'h11AB_3344, 0, 2));
    vecs.push_back(mk(1, 3'b001, 32'h206, 32'h0000_BEEF, 32'h206, 4'b1100,
                      32'hBEEF_BEEF, 0, 0, 1));
    vecs.push_back(mk(0, 3'b001, 32'h206, 0, 32'h206, 0, 0,
                      32'hFFFF_BEEF, 0, 2));
    vecs.push_back(mk(0, 3'b010, 32'h204, 0, 32'h204, 0, 0,
                      32'hBEEF_0000, 0, 2));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 3'b010, 32'h102, 0, 32'h102, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 3'b010, 32'h1FFFE, 0, 32'h1FFFE, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 3'b001, 32'h1FFFF, 0, 32'h1FFFF, 0, 0, 0, 1, 1));
`else
    vecs.push_back(mk(0, 3'b010, 32'h102, 0, 32'h100, 0, 0,
                      32'h8844_22F1, 0, 2));
    vecs.push_back(mk(0, 3'b010, 32'h1FFFE, 0, 32'h1FFFC, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 3'b001, 32'h1FFFF, 0, 32'h1FFFE, 0, 0, 0, 1, 1));
`endif
    vecs.push_back(mk(0, 3'b100, 32'h1FFFF, 0, 32'h1FFFF, 0, 0,
                      32'h0000_007F, 0, 2));
    vecs.push_back(mk(0, 3'b011, 32'h100, 0, 32'h100, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3'b100, 32'h200, 32'h55, 32'h200, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3'b010, 32'h208, 32'hDEAD_BEEF, 32'h208, 4'hF,
                      32'hDEAD_BEEF, 0, 0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h208, 0, 32'h208, 0, 0,
                      32'hDEAD_BEEF, 0, 2));

    // Reset state, with a load request present.
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_ren", 32'(mem_ren), 32'd0);
    check("rst mem_mask", 32'(mem_mask), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_fault", 32'(resp_fault), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    req_valid = 1'b0;

    foreach (vecs[i]) run(vecs[i], i);

    // Back-pressure: response must hold while resp_ready stays low.
    @(posedge clk); #1;
    drive(1'b0, 3'b010, 32'h100, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(cyc);
    check("stall latency", 32'(cyc), 32'd2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("stall%0d rdata", k), resp_rdata, 32'h8844_22F1);
      check($sformatf("stall%0d req_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    drive(1'b0, 3'b100, 32'h101, 32'h0);
    resp_ready = 1'b1;
    #1;
    check("stall no_accept", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_hs valid", 32'(resp_valid), 32'd0);
    check("post_hs req_ready", 32'(req_ready), 32'd1);
    check("post_hs mem_ren", 32'(mem_ren), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(cyc);
    check("post_hs latency", 32'(cyc), 32'd2);
    check("post_hs rdata", resp_rdata, 32'h0000_0022);
    handshake();

    // Reset while the load is in RD_WAIT drops it entirely.
    drive(1'b0, 3'b010, 32'h200, 32'h0);
    @(posedge clk); #1;
    check("rdw req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rdw idle", 32'(req_ready), 32'd1);
    check("rdw resp_valid", 32'(resp_valid), 32'd0);
    check("rdw gated ren", 32'(mem_ren), 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rdw quiet%0d", k), 32'(resp_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
